// File: rtl/floo_addr_decode.sv
// Rule-based address/ID decoder: maps addr_i onto an output index through a runtime table of
// range or NAPOT rules, with optional default-index fallback and an optional output register.
module floo_addr_decode #(
   parameter int unsigned NoIndices = 1,
   parameter int unsigned NoRules   = 1,
   parameter type         addr_t    = logic,
   localparam int unsigned IdxWidth = (NoIndices > 1) ? $clog2(NoIndices) : 1,
   parameter type         rule_t    = logic [IdxWidth+2*$bits(addr_t)-1:0],
   parameter bit          Napot     = 1'b0,
   parameter bit          RegOutput = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  addr_t                 addr_i,
   input  rule_t [NoRules-1:0]   addr_map_i,
   input  logic                  en_default_idx_i,
   input  logic [IdxWidth-1:0]   default_idx_i,
   output logic [IdxWidth-1:0]   idx_o,
   output logic                  dec_valid_o,
   output logic                  dec_error_o
);

   localparam int unsigned AW    = $bits(addr_t);
   localparam int unsigned RuleW = IdxWidth + 2 * AW;

   logic [AW-1:0]       w_addr;
   logic [RuleW-1:0]    w_rule_bits [NoRules];
   logic [AW-1:0]       w_start     [NoRules];
   logic [AW-1:0]       w_end       [NoRules];
   logic [IdxWidth-1:0] w_rule_idx  [NoRules];
   logic [NoRules-1:0]  w_match;

   logic                w_hit;
   logic [IdxWidth-1:0] w_hit_idx;
   logic [IdxWidth-1:0] w_idx;
   logic                w_valid;
   logic                w_error;

   assign w_addr = addr_i;

   // Rule layout, MSB to LSB: idx | start_addr | end_addr (end_addr is the mask in NAPOT mode).
   for (genvar i = 0; i < int'(NoRules); i++) begin : g_rule
      assign w_rule_bits[i] = addr_map_i[i];
      assign w_end[i]       = w_rule_bits[i][AW-1:0];
      assign w_start[i]     = w_rule_bits[i][2*AW-1:AW];
      assign w_rule_idx[i]  = w_rule_bits[i][RuleW-1:2*AW];

      if (Napot) begin : g_napot
         assign w_match[i] = (w_addr & w_end[i]) == (w_start[i] & w_end[i]);
      end else begin : g_range
         assign w_match[i] = (w_addr >= w_start[i]) &&
                             ((w_addr < w_end[i]) || (w_end[i] == '0));
      end

      always_comb begin
         a_idx_in_range: assert (int'(w_rule_idx[i]) < int'(NoIndices));
         if (!Napot && (w_end[i] != '0)) begin
            a_range_order: assert (w_start[i] <= w_end[i]);
         end
      end
   end

   // Ascending scan, so the highest-numbered matching rule wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < int'(NoRules); i++) begin
         if (w_match[i]) begin
            w_hit     = 1'b1;
            w_hit_idx = w_rule_idx[i];
         end
      end
   end

   always_comb begin
      w_idx   = '0;
      w_valid = w_hit;
      w_error = ~w_hit & ~en_default_idx_i;
      if (w_hit) begin
         w_idx = w_hit_idx;
      end else if (en_default_idx_i) begin
         w_idx = default_idx_i;
      end
   end

   if (RegOutput) begin : g_reg
      logic [IdxWidth-1:0] r_idx;
      logic                r_valid;
      logic                r_error;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
         end else begin
            r_idx   <= w_idx;
            r_valid <= w_valid;
            r_error <= w_error;
         end
      end

      assign idx_o       = r_idx;
      assign dec_valid_o = r_valid;
      assign dec_error_o = r_error;
   end else begin : g_comb
      // Clock and reset only matter when the output register is present.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk_i ^ rst_ni;

      assign idx_o       = w_idx;
      assign dec_valid_o = w_valid;
      assign dec_error_o = w_error;
   end

endmodule

// File: tb/tb_floo_addr_decode.sv
// Directed bench for floo_addr_decode: combinational range and NAPOT instances plus a registered one.
module tb_floo_addr_decode;

   typedef logic [7:0] addr8_t;
   typedef struct packed {
      logic [1:0] idx;
      addr8_t     start_addr;
      addr8_t     end_addr;
   } rule8_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   addr8_t      addr = '0;
   logic        en_def = 1'b0;
   logic [1:0]  def_idx = '0;

   rule8_t [1:0] map_rng = '0;
   rule8_t [0:0] map_napot = '0;
   rule8_t [1:0] map_reg = '0;

   logic [1:0] rng_idx, napot_idx, reg_idx;
   logic       rng_valid, napot_valid, reg_valid;
   logic       rng_err, napot_err, reg_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   floo_addr_decode #(
      .NoIndices(4), .NoRules(2), .addr_t(addr8_t), .rule_t(rule8_t),
      .Napot(1'b0), .RegOutput(1'b0)
   ) u_rng (
      .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .addr_map_i(map_rng),
      .en_default_idx_i(en_def), .default_idx_i(def_idx),
      .idx_o(rng_idx), .dec_valid_o(rng_valid), .dec_error_o(rng_err)
   );

   floo_addr_decode #(
      .NoIndices(4), .NoRules(1), .addr_t(addr8_t), .rule_t(rule8_t),
      .Napot(1'b1), .RegOutput(1'b0)
   ) u_napot (
      .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .addr_map_i(map_napot),
      .en_default_idx_i(en_def), .default_idx_i(def_idx),
      .idx_o(napot_idx), .dec_valid_o(napot_valid), .dec_error_o(napot_err)
   );

   floo_addr_decode #(
      .NoIndices(4), .NoRules(2), .addr_t(addr8_t), .rule_t(rule8_t),
      .Napot(1'b0), .RegOutput(1'b1)
   ) u_reg (
      .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .addr_map_i(map_reg),
      .en_default_idx_i(en_def), .default_idx_i(def_idx),
      .idx_o(reg_idx), .dec_valid_o(reg_valid), .dec_error_o(reg_err)
   );

   // Expected values below are packed as {idx[1:0], valid, error}.

   task automatic test_reset();
      #1;
      n_vec++;
      if ({reg_idx, reg_valid, reg_err} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_initial got=%b want=0000", {reg_idx, reg_valid, reg_err});
      end
   endtask

   task automatic test_range_hits();
      addr8_t     a [6] = '{8'h10, 8'h1F, 8'h20, 8'h30, 8'h0F, 8'h2F};
      logic [3:0] e [6] = '{4'b0110, 4'b0110, 4'b1010, 4'b0001, 4'b0001, 4'b1010};
      en_def     = 1'b0;
      map_rng[0] = '{idx: 2'd1, start_addr: 8'h10, end_addr: 8'h20};
      map_rng[1] = '{idx: 2'd2, start_addr: 8'h20, end_addr: 8'h30};
      for (int k = 0; k < 6; k++) begin
         addr = a[k];
         #1;
         n_vec++;
         if ({rng_idx, rng_valid, rng_err} !== e[k]) begin
            n_err++;
            $display("FAIL range_hit addr=%h got=%b want=%b", a[k], {rng_idx, rng_valid, rng_err}, e[k]);
         end
      end
   endtask

   task automatic test_overlap();
      addr8_t     a [6] = '{8'h50, 8'h90, 8'h40, 8'h7F, 8'h80, 8'h00};
      logic [3:0] e [6] = '{4'b1110, 4'b0110, 4'b1110, 4'b1110, 4'b0110, 4'b0110};
      map_rng[1] = '{idx: 2'd3, start_addr: 8'h40, end_addr: 8'h80};
      map_rng[0] = '{idx: 2'd1, start_addr: 8'h00, end_addr: 8'h00};
      for (int k = 0; k < 6; k++) begin
         addr = a[k];
         #1;
         n_vec++;
         if ({rng_idx, rng_valid, rng_err} !== e[k]) begin
            n_err++;
            $display("FAIL overlap addr=%h got=%b want=%b", a[k], {rng_idx, rng_valid, rng_err}, e[k]);
         end
      end
   endtask

   task automatic test_open_end();
      addr8_t     a [4] = '{8'hFF, 8'hF0, 8'hEF, 8'h00};
      logic [3:0] e [4] = '{4'b1010, 4'b1010, 4'b0001, 4'b0010};
      map_rng[0] = '{idx: 2'd2, start_addr: 8'hF0, end_addr: 8'h00};
      map_rng[1] = '{idx: 2'd0, start_addr: 8'h00, end_addr: 8'h01};
      for (int k = 0; k < 4; k++) begin
         addr = a[k];
         #1;
         n_vec++;
         if ({rng_idx, rng_valid, rng_err} !== e[k]) begin
            n_err++;
            $display("FAIL open_end addr=%h got=%b want=%b", a[k], {rng_idx, rng_valid, rng_err}, e[k]);
         end
      end
   endtask

   task automatic test_default();
      addr8_t     a [4] = '{8'hEF, 8'hEF, 8'hEF, 8'hFF};
      logic       en [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      logic [1:0] d [4] = '{2'd3, 2'd3, 2'd1, 2'd3};
      logic [3:0] e [4] = '{4'b1100, 4'b0001, 4'b0100, 4'b1010};
      for (int k = 0; k < 4; k++) begin
         addr    = a[k];
         en_def  = en[k];
         def_idx = d[k];
         #1;
         n_vec++;
         if ({rng_idx, rng_valid, rng_err} !== e[k]) begin
            n_err++;
            $display("FAIL default addr=%h en=%b def=%0d got=%b want=%b",
                     a[k], en[k], d[k], {rng_idx, rng_valid, rng_err}, e[k]);
         end
      end
      en_def  = 1'b0;
      def_idx = '0;
   endtask

   task automatic test_napot();
      addr8_t     a [5] = '{8'h7F, 8'h80, 8'h40, 8'h3F, 8'hAA};
      rule8_t     r [5];
      logic [3:0] e [5] = '{4'b0110, 4'b0001, 4'b0110, 4'b0001, 4'b1010};
      r[0] = '{idx: 2'd1, start_addr: 8'h40, end_addr: 8'hC0};
      r[1] = r[0];
      r[2] = r[0];
      r[3] = r[0];
      r[4] = '{idx: 2'd2, start_addr: 8'h55, end_addr: 8'h00};
      for (int k = 0; k < 5; k++) begin
         map_napot[0] = r[k];
         addr = a[k];
         #1;
         n_vec++;
         if ({napot_idx, napot_valid, napot_err} !== e[k]) begin
            n_err++;
            $display("FAIL napot addr=%h got=%b want=%b", a[k], {napot_idx, napot_valid, napot_err}, e[k]);
         end
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      rst_n = 1'b1;
      addr  = 8'h20;
      @(posedge clk);
      #1;
      n_vec++;
      if ({reg_idx, reg_valid, reg_err} !== 4'b1010) begin
         n_err++;
         $display("FAIL reg_capture got=%b want=1010", {reg_idx, reg_valid, reg_err});
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({reg_idx, reg_valid, reg_err} !== 4'b0000) begin
         n_err++;
         $display("FAIL reg_async_reset got=%b want=0000", {reg_idx, reg_valid, reg_err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      addr  = 8'h10;
      #1;
      n_vec++;
      if ({reg_idx, reg_valid, reg_err} !== 4'b0000) begin
         n_err++;
         $display("FAIL reg_before_edge got=%b want=0000", {reg_idx, reg_valid, reg_err});
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({reg_idx, reg_valid, reg_err} !== 4'b0110) begin
         n_err++;
         $display("FAIL reg_after_release got=%b want=0110", {reg_idx, reg_valid, reg_err});
      end
      addr = 8'h30;
      #1;
      n_vec++;
      if ({reg_idx, reg_valid, reg_err} !== 4'b0110) begin
         n_err++;
         $display("FAIL reg_hold got=%b want=0110", {reg_idx, reg_valid, reg_err});
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({reg_idx, reg_valid, reg_err} !== 4'b0001) begin
         n_err++;
         $display("FAIL reg_miss got=%b want=0001", {reg_idx, reg_valid, reg_err});
      end
   endtask

   initial begin
      map_reg[0] = '{idx: 2'd1, start_addr: 8'h10, end_addr: 8'h20};
      map_reg[1] = '{idx: 2'd2, start_addr: 8'h20, end_addr: 8'h30};
      test_reset();
      test_range_hits();
      test_overlap();
      test_open_end();
      test_default();
      test_napot();
      test_registered();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
